filter_chunk_loader: RTL

- Read sequencer and chunk buffer directly downstream of the filter SRAM model.
- Drives the SRAM's data-cycle and chunk indices, and receives the combinational BUS_SIZE-wide sparsemap and nonzero-data slices.
- Assembles one full chunk per load and computes its nonzero count.
- Presents the chunk to the PE array with a valid/ready handshake, iterating over a programmed range of chunks.

---
 rtl/filter_chunk_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/filter_chunk_loader.sv
// Reads one chunk at a time from the filter SRAM, one BUS_SIZE slice per cycle, and holds the
// assembled chunk (with its nonzero count) for the PE array behind a valid/ready handshake.
module filter_chunk_loader #(
  parameter int unsigned BUS_SIZE        = 8,
  parameter int unsigned CHUNK_SIZE      = 32,
  parameter int unsigned WR_DAT_CYC_NUM  = CHUNK_SIZE / BUS_SIZE,
  parameter int unsigned SRAM_FILTER_NUM = 16,
  localparam int unsigned DW = $clog2(WR_DAT_CYC_NUM),
  localparam int unsigned CW = $clog2(SRAM_FILTER_NUM),
  localparam int unsigned NW = $clog2(CHUNK_SIZE) + 1,
  localparam int unsigned BW = $clog2(BUS_SIZE) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CW-1:0]           chunk_base_i,
  input  logic [CW:0]             chunk_num_i,
  output logic [DW-1:0]           rd_dat_count_o,
  output logic [CW-1:0]           rd_chunk_count_o,
  input  logic [BUS_SIZE-1:0]     rd_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]   rd_nonzero_data_i,
  output logic [CHUNK_SIZE-1:0]   chunk_sparsemap_o,
  output logic [CHUNK_SIZE*8-1:0] chunk_data_o,
  output logic [NW-1:0]           chunk_nz_cnt_o,
  output logic [CW-1:0]           chunk_idx_o,
  output logic                    chunk_valid_o,
  input  logic                    chunk_ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StFin} state_e;

  state_e        state_q;
  logic [CW:0]   remain_q;
  logic [BW-1:0] slice_pop;
  logic          last_slice;
  logic [CW-1:0] next_chunk;

  always_comb begin
    slice_pop = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      slice_pop = slice_pop + BW'(rd_sparsemap_i[i]);
    end
  end

  assign last_slice = (rd_dat_count_o == DW'(WR_DAT_CYC_NUM - 1));
  // Explicit wrap keeps the index legal when SRAM_FILTER_NUM is not a power of two.
  assign next_chunk = (rd_chunk_count_o == CW'(SRAM_FILTER_NUM - 1)) ? '0
                                                                     : rd_chunk_count_o + CW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      remain_q          <= '0;
      rd_dat_count_o    <= '0;
      rd_chunk_count_o  <= '0;
      chunk_sparsemap_o <= '0;
      chunk_data_o      <= '0;
      chunk_nz_cnt_o    <= '0;
      chunk_idx_o       <= '0;
      chunk_valid_o     <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (chunk_num_i != '0) begin
              remain_q         <= chunk_num_i;
              rd_chunk_count_o <= chunk_base_i;
              rd_dat_count_o   <= '0;
              chunk_nz_cnt_o   <= '0;
              state_q          <= StLoad;
            end else begin
              done_o  <= 1'b1;
              state_q <= StFin;
            end
          end
        end
        StLoad: begin
          chunk_sparsemap_o[rd_dat_count_o*BUS_SIZE +: BUS_SIZE] <= rd_sparsemap_i;
          chunk_data_o[rd_dat_count_o*BUS_SIZE*8 +: BUS_SIZE*8]  <= rd_nonzero_data_i;
          chunk_nz_cnt_o <= chunk_nz_cnt_o + NW'(slice_pop);
          if (last_slice) begin
            rd_dat_count_o <= '0;
            chunk_idx_o    <= rd_chunk_count_o;
            chunk_valid_o  <= 1'b1;
            state_q        <= StHold;
          end else begin
            rd_dat_count_o <= rd_dat_count_o + DW'(1);
          end
        end
        StHold: begin
          if (chunk_ready_i) begin
            chunk_valid_o <= 1'b0;
            remain_q      <= remain_q - (CW+1)'(1);
            if (remain_q > (CW+1)'(1)) begin
              rd_chunk_count_o <= next_chunk;
              chunk_nz_cnt_o   <= '0;
              state_q          <= StLoad;
            end else begin
              done_o  <= 1'b1;
              state_q <= StFin;
            end
          end
        end
        StFin: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
